// File: rtl/vend_sequencer.sv
// vend_sequencer: vending machine dispense motor and change ejector sequencer
module vend_sequencer #(
    parameter int MOTOR_CYCLES = 4,
    parameter int EJECT_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [3:0] change_coins,
    output logic       cmd_ready,
    output logic       motor_on,
    output logic       coin_eject,
    output logic       done,
    output logic       overrun
);
    typedef enum logic [2:0] {IDLE, DISPENSE, EJECT, GAP, DONE} state_t;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] coins_q, coins_d;
    logic [1:0] cmd_q, cmd_d;
    logic       ready_q, overrun_q, overrun_d, accept;
    always_comb begin
        accept    = cmd_valid && ready_q && cmd != 2'b00;
        state_d   = state_q;
        cnt_d     = cnt_q;
        coins_d   = coins_q;
        cmd_d     = cmd_q;
        overrun_d = accept ? 1'b0 : (cmd_valid && !ready_q) ? 1'b1 : overrun_q;
        case (state_q)
            IDLE: if (accept) begin
                cmd_d   = cmd;
                coins_d = change_coins;
                cnt_d   = 8'(MOTOR_CYCLES - 1);
                state_d = cmd[1] ? DISPENSE : (change_coins != 4'd0) ? EJECT : DONE;
            end
            DISPENSE: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q != 8'd0) ? DISPENSE :
                          (cmd_q == 2'b11 && coins_q != 4'd0) ? EJECT : DONE;
            end
            EJECT: begin
                coins_d = coins_q - 4'd1;
                cnt_d   = 8'(EJECT_GAP - 1);
                state_d = (coins_q == 4'd1) ? DONE : GAP;
            end
            GAP: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd0) ? EJECT : GAP;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // ready is registered from next state so it stays low through reset and its release cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            coins_q   <= 4'd0;
            cmd_q     <= 2'b00;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            coins_q   <= coins_d;
            cmd_q     <= cmd_d;
            ready_q   <= state_d == IDLE;
            overrun_q <= overrun_d;
        end
    end
    assign cmd_ready  = ready_q;
    assign motor_on   = state_q == DISPENSE;
    assign coin_eject = state_q == EJECT;
    assign done       = state_q == DONE;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: randomized scenario bench for vend_sequencer against a timing-formula model
module tb_vend_sequencer;
    localparam int M = 4;
    localparam int G = 2;
    logic       clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [3:0] change_coins = 4'd0;
    logic       cmd_ready, motor_on, coin_eject, done, overrun;
    int         total = 0, bad = 0;

    vend_sequencer #(.MOTOR_CYCLES(M), .EJECT_GAP(G)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .change_coins(change_coins),
        .cmd_ready(cmd_ready), .motor_on(motor_on), .coin_eject(coin_eject), .done(done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL wait_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    // Expected timeline from the command rules: motor for M cycles, then one coin every G+1 cycles, then done.
    task automatic run_cmd(input string name, input logic [1:0] c, input logic [3:0] k, input int poke_in);
        int n, start, fin, poke;
        logic [4:0] got, exp;
        n     = c[0] ? int'(k) : 0;
        start = c[1] ? M + 1 : 1;
        fin   = (n != 0) ? start + (n - 1) * (G + 1) + 1 : start;
        poke  = (poke_in > fin) ? 0 : poke_in;
        wait_ready();
        cmd_valid = 1'b1;
        cmd = c;
        change_coins = k;
        step();
        for (int cyc = 1; cyc <= fin + 1; cyc++) begin
            cmd_valid = (cyc == poke);
            cmd = (cyc == poke) ? 2'($urandom_range(1, 3)) : 2'($urandom);
            change_coins = 4'($urandom);
            exp = {cyc == fin + 1,
                   c[1] && cyc <= M,
                   n != 0 && cyc >= start && cyc < fin && (cyc - start) % (G + 1) == 0,
                   cyc == fin,
                   poke != 0 && cyc > poke};
            @(negedge clk);
            got = {cmd_ready, motor_on, coin_eject, done, overrun};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s cyc%0d: {rdy,mot,ej,done,ovr}=%b required %b", name, cyc, got, exp);
            end
            step();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({cmd_ready, motor_on, coin_eject, done, overrun} !== 5'b0) begin
            bad++;
            $display("FAIL reset: outputs=%b required 00000",
                     {cmd_ready, motor_on, coin_eject, done, overrun});
        end
        step();
        step();
        rst = 1'b0;
        step();
        total++;
        if ({cmd_ready, motor_on, coin_eject, done, overrun} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_release: outputs=%b required 10000",
                     {cmd_ready, motor_on, coin_eject, done, overrun});
        end
    endtask

    task automatic test_nop();
        wait_ready();
        cmd_valid = 1'b1;
        cmd = 2'b00;
        for (int i = 0; i < 3; i++) begin
            change_coins = 4'($urandom);
            @(negedge clk);
            total++;
            if ({cmd_ready, motor_on, coin_eject, done, overrun} !== 5'b10000) begin
                bad++;
                $display("FAIL nop%0d: outputs=%b required 10000", i,
                         {cmd_ready, motor_on, coin_eject, done, overrun});
            end
            step();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_mid(input string name, input logic [1:0] c, input logic [3:0] k, input int rc);
        wait_ready();
        cmd_valid = 1'b1;
        cmd = c;
        change_coins = k;
        step();
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc < rc; cyc++) step();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({cmd_ready, motor_on, coin_eject, done, overrun} !== 5'b0) begin
            bad++;
            $display("FAIL %s async: outputs=%b required 00000", name,
                     {cmd_ready, motor_on, coin_eject, done, overrun});
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            total++;
            if (i == 0 ? ({motor_on, coin_eject, done} !== 3'b000)
                       : ({cmd_ready, motor_on, coin_eject, done, overrun} !== 5'b10000)) begin
                bad++;
                $display("FAIL %s post%0d: outputs=%b required %s", name, i,
                         {cmd_ready, motor_on, coin_eject, done, overrun}, i == 0 ? "x0000" : "10000");
            end
            step();
        end
    endtask

    task automatic test_directed();
        run_cmd("disp", 2'b10, 4'd7, 0);
        run_cmd("disp_change", 2'b11, 4'd2, 0);
        run_cmd("refund5", 2'b01, 4'd5, 0);
        run_cmd("refund0", 2'b01, 4'd0, 0);
        run_cmd("change0", 2'b11, 4'd0, 0);
        run_cmd("refund15", 2'b01, 4'd15, 0);
    endtask

    task automatic test_overrun();
        run_cmd("ovr", 2'b10, 4'd0, 2);
        run_cmd("after_ovr", 2'b10, 4'd0, 0);
        run_cmd("ovr_done", 2'b01, 4'd0, 1);
        run_cmd("after_ovr_done", 2'b11, 4'd1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            run_cmd("rand", 2'($urandom_range(1, 3)), 4'($urandom),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0);
    endtask

    initial begin
        test_reset();
        test_nop();
        test_directed();
        test_overrun();
        test_reset_mid("rst_gap", 2'b11, 4'd3, 6);
        test_reset_mid("rst_motor", 2'b10, 4'd0, 2);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter MOTOR_CYCLES, default 4: motor_on high time per dispense, range 1..255.
REQ-002 SHALL have parameter EJECT_GAP, default 2: low cycles between successive coin_eject pulses, range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid, input, 1 bit: a command is presented on cmd and change_coins.
REQ-006 SHALL have port cmd, input, 2 bits: 2'b10 dispense; 2'b11 dispense plus change; 2'b01 refund (cancel); 2'b00 none.
REQ-007 SHALL have port change_coins, input, 4 bits: number of 5c coins to eject, 0..15.
REQ-008 SHALL have port cmd_ready, output, 1 bit: block is idle and accepts a command this cycle.
REQ-009 SHALL have port motor_on, output, 1 bit: product dispense motor drive.
REQ-010 SHALL have port coin_eject, output, 1 bit: one-cycle pulse per 5c coin ejected.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a command completes.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag, command presented while busy.

Function
REQ-013 SHALL implement states IDLE, DISPENSE, EJECT, GAP, DONE.
REQ-014 SHALL drive all outputs from registers or decoded state only; no combinational path from inputs to outputs.
REQ-015 SHALL drive cmd_ready high only in IDLE.
REQ-016 SHALL accept a command on a rising edge with cmd_valid=1, cmd_ready=1, cmd!=2'b00, capturing cmd and change_coins.
REQ-017 SHALL ignore cmd_valid=1 with cmd=2'b00 in IDLE: no state change, no flag.
REQ-018 SHALL transition IDLE->DISPENSE on acceptance of cmd 10 or 11.
REQ-019 SHALL transition IDLE->EJECT on acceptance of cmd 01 with change_coins>0.
REQ-020 SHALL transition IDLE->DONE on acceptance of cmd 01 with change_coins=0.
REQ-021 SHALL hold motor_on=1 in DISPENSE for exactly MOTOR_CYCLES cycles.
REQ-022 SHALL leave DISPENSE to EJECT if the captured cmd=11 and captured coins>0; otherwise to DONE.
REQ-023 SHALL hold coin_eject=1 for exactly one cycle in EJECT and decrement the remaining-coin count.
REQ-024 SHALL go from EJECT to GAP if coins remain after the decrement, otherwise directly to DONE.
REQ-025 SHALL hold GAP for EJECT_GAP cycles with coin_eject=0, then return to EJECT.
REQ-026 SHALL pulse done for one cycle in DONE and return to IDLE on the next edge.
REQ-027 SHALL set overrun when cmd_valid=1 on an edge where cmd_ready=0.
REQ-028 SHALL clear overrun only on the next accepted command or on reset; the command presented while busy is dropped.
REQ-029 SHALL keep the captured command immune to input changes during execution.
REQ-030 SHALL NOT assert motor_on and coin_eject in the same cycle.

Reset
REQ-031 SHALL, while rst=1 (immediately, without waiting for clk), force state IDLE, counters 0, motor_on=0, coin_eject=0, done=0, overrun=0.
REQ-032 SHALL drive cmd_ready=0 while rst=1 and cmd_ready=1 from the first cycle after deassertion.
REQ-033 SHALL discard, with no done pulse, any command in progress when reset asserts mid-operation.

Verification (MOTOR_CYCLES=4, EJECT_GAP=2; cmd accepted at edge ending cycle 0)
REQ-034 SHALL be verified with: cmd=10 -> motor_on=1 in cycles 1-4; done in cycle 5; cmd_ready=1 in cycle 6; coin_eject never asserted.
REQ-035 SHALL be verified with: cmd=11, change_coins=2 -> motor_on in cycles 1-4; coin_eject in cycles 5 and 8; done in cycle 9.
REQ-036 SHALL be verified with: cmd=01, change_coins=5 -> coin_eject in cycles 1, 4, 7, 10, 13; done in cycle 14; motor_on never asserted.
REQ-037 SHALL be verified with: cmd=01, change_coins=0 -> done in cycle 1; no motor_on, no coin_eject.
REQ-038 SHALL be verified with: cmd=11, coins=3, rst pulsed in cycle 6 -> outputs 0 asynchronously; no further coin_eject; no done; cmd_ready=1 after release.
REQ-039 SHALL be verified with: cmd_valid=1 in cycle 2 of a cmd=10 run -> overrun=1, original timing unchanged; overrun=0 after next accepted command.
